pam_norm_scan: RTL

Normalization-scan controller for the PAM read path. On a start command it streams a block of words out of PAM, one read per cycle, and counts leading zeros in each returned word with an internal LZCU instance. It reports the smallest shift amount in the block, the index of the first word that has it, and an all-zero flag; the block-floating-point normalizer uses these as its common shift.

---
 rtl/pam_norm_scan.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pam_norm_scan.sv
// rtl/pam_norm_scan.sv - PAM block normalization scan: min leading-zero count over a word block

// Leading-zero counter: returns I_WIDTH for an all-zero word.
module pam_lzcu #(
  parameter int LZC_WIDTH = 7,
  parameter int I_WIDTH   = 2**(LZC_WIDTH-1)
) (
  input  logic [I_WIDTH-1:0]   i_data,
  output logic [LZC_WIDTH-1:0] o_shamt
);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    o_shamt = LZC_WIDTH'(I_WIDTH);
    for (int b = 0; b < I_WIDTH; b++) begin
      if (i_data[b]) begin
        o_shamt = LZC_WIDTH'(I_WIDTH - 1 - b);
      end
    end
  end

endmodule

module pam_norm_scan #(
  parameter int LZC_WIDTH  = 7,
  parameter int I_WIDTH    = 2**(LZC_WIDTH-1),
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  pam_ren,
  output logic [ADDR_WIDTH-1:0] pam_raddr,
  input  logic [I_WIDTH-1:0]    pam_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [LZC_WIDTH-1:0]  min_shamt,
  output logic [ADDR_WIDTH-1:0] min_idx,
  output logic                  all_zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LZC_WIDTH-1:0] ZERO_WORD_SHAMT = LZC_WIDTH'(I_WIDTH);

  state_t                r_state;
  state_t                w_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_vidx;
  logic [LZC_WIDTH-1:0]  r_min;
  logic [ADDR_WIDTH-1:0] r_min_idx;
  logic                  r_res;
  logic [LZC_WIDTH-1:0]  w_shamt;
  logic                  w_hit0;
  logic                  w_accept;

  pam_lzcu #(
    .LZC_WIDTH (LZC_WIDTH),
    .I_WIDTH   (I_WIDTH)
  ) u_lzcu (
    .i_data  (pam_rdata),
    .o_shamt (w_shamt)
  );

  assign w_accept = (r_state == S_IDLE) && start;
  // A zero shift cannot be beaten, so the scan stops as soon as one is captured.
  assign w_hit0   = r_vld && (w_shamt == '0);

  // Next-state selection; early exit overrides every non-idle state.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt = (len != '0) ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        if (w_hit0) begin
          w_nxt = S_DONE;
        end else if (r_cnt == r_len - 1'b1) begin
          w_nxt = S_DRAIN;
        end
      end
      S_DRAIN: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, read counter, capture pipe and running minimum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_vld     <= 1'b0;
      r_vidx    <= '0;
      r_min     <= '0;
      r_min_idx <= '0;
      r_res     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // Read issued this cycle returns next cycle; a read in flight at early exit is dropped.
      r_vld   <= (r_state == S_SCAN) && !w_hit0;
      r_vidx  <= r_cnt;
      if (r_state == S_SCAN) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_base    <= base_addr;
        r_len     <= len;
        r_cnt     <= '0;
        r_min     <= ZERO_WORD_SHAMT;
        r_min_idx <= '0;
        r_res     <= (len == '0);
      end else begin
        // Strictly-less keeps the earliest index on ties.
        if (r_vld && (w_shamt < r_min)) begin
          r_min     <= w_shamt;
          r_min_idx <= r_vidx;
        end
        if ((r_state != S_IDLE) && (r_state != S_DONE) && (w_nxt == S_DONE)) begin
          r_res <= 1'b1;
        end
      end
    end
  end

  assign pam_ren   = (r_state == S_SCAN);
  assign pam_raddr = (r_state == S_SCAN) ? (r_base + r_cnt) : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign min_shamt = r_min;
  assign min_idx   = r_min_idx;
  assign all_zero  = r_res && (r_min == ZERO_WORD_SHAMT);

endmodule
